// File: rtl/seq_right_shifter.sv
// Sequential 32-bit right shifter: SRL/SRA one bit per clock, with optional rotate.
// Rotate right is built only when SEQ_RIGHT_SHIFTER_ROTR_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | shifting one bit per cycle, amt counting down to 0
// DONE  | result valid on dataOut, done pulse (err if op unsupported)
module seq_right_shifter #(
  parameter logic [5:0] SRL_CODE  = 6'b000010,
  parameter logic [5:0] SRA_CODE  = 6'b000011,
  parameter logic [5:0] ROTR_CODE = 6'b000100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] sreg;
  logic [31:0] shifted;
  logic [4:0]  amt;
  logic [5:0]  op;
  logic        accept;
  logic        op_ok;
  logic        fill;

  always_comb begin
    op_ok = (Signal == SRL_CODE) || (Signal == SRA_CODE);
`ifdef SEQ_RIGHT_SHIFTER_ROTR_EN
    if (Signal == ROTR_CODE) op_ok = 1'b1;
`endif
  end

  // only supported ops ever reach SHIFT, so op selects among valid fills
  always_comb begin
    fill = 1'b0;
    if (op == SRA_CODE) fill = sreg[31];
`ifdef SEQ_RIGHT_SHIFTER_ROTR_EN
    if (op == ROTR_CODE) fill = sreg[0];
`endif
    shifted = {fill, sreg[31:1]};
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          accept = 1'b1;
          if ((dataB[4:0] == 5'd0) || !op_ok) state_nxt = DONE;
          else                                state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (amt == 5'd1) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg    <= 32'd0;
      amt     <= 5'd0;
      op      <= 6'd0;
      dataOut <= 32'd0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        sreg <= dataA;
        amt  <= dataB[4:0];
        op   <= Signal;
        if (state_nxt == DONE) begin
          dataOut <= op_ok ? dataA : 32'd0;
          err     <= !op_ok;
        end
      end else if (state == SHIFT) begin
        sreg <= shifted;
        amt  <= amt - 5'd1;
        if (state_nxt == DONE) dataOut <= shifted;
      end
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_right_shifter.sv
// Scoreboard bench for seq_right_shifter: expected results queued at start, checked on done.
// Honours SEQ_RIGHT_SHIFTER_ROTR_EN the same way as the design.
module tb_seq_right_shifter;

  localparam logic [5:0] SRL  = 6'b000010;
  localparam logic [5:0] SRA  = 6'b000011;
  localparam logic [5:0] ROTR = 6'b000100;
  localparam logic [5:0] BAD  = 6'b111111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  Signal = 6'd0;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic [31:0] dataOut;
  logic        busy, done, err;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    int          nbusy;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  logic [31:0] last_out = 32'd0;

  seq_right_shifter dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .dataOut(dataOut),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   k;
    logic ok;
    k  = int'(b[4:0]);
    ok = (opc == SRL) || (opc == SRA);
`ifdef SEQ_RIGHT_SHIFTER_ROTR_EN
    if (opc == ROTR) ok = 1'b1;
`endif
    e.err = !ok;
    if (!ok) begin
      e.data = 32'd0;
      k      = 0;
    end else if (opc == SRL) begin
      e.data = a >> k;
    end else if (opc == SRA) begin
      e.data = $signed(a) >>> k;
    end else begin
      e.data = (k == 0) ? a : ((a >> k) | (a << (32 - k)));
    end
    e.cyc   = cyc + 1 + k;
    e.nbusy = k;
    return e;
  endfunction

  // caller sits just after a rising edge; start is held for exactly one cycle
  task automatic issue(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(opc, a, b));
    Signal = opc; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic poke(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b);
    Signal = opc; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !busy && !done) break;
      @(posedge clk); #1;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        chk("hold_in_shift", dataOut, last_out);
        busy_cnt++;
      end
      if (!done) chk("err_without_done", err, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("data", dataOut, e.data);
          chk("err", err, e.err);
          chk("latency", cyc, e.cyc);
          chk("busy_cycles", busy_cnt, e.nbusy);
        end
        busy_cnt = 0;
      end
    end
    last_out = dataOut;
  end

  initial begin
    logic [5:0] ops[4];
    ops[0] = SRL; ops[1] = SRA; ops[2] = ROTR; ops[3] = BAD;

    #2;
    chk("reset_outputs", {dataOut, busy, done, err}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    issue(SRL, 32'h8000_0000, 32'd4);
    drain("drain_srl4");
    issue(SRA, 32'h8000_0000, 32'h0000_0025);
    drain("drain_sra5");
    issue(SRL, 32'h1234_5678, 32'd0);
    drain("drain_srl0");
    issue(BAD, 32'hFFFF_FFFF, 32'd7);
    drain("drain_bad");

    // start during SHIFT must be ignored
    issue(SRL, 32'hDEAD_BEEF, 32'd8);
    repeat (2) @(posedge clk);
    #1 poke(SRA, 32'h5555_5555, 32'd3);
    drain("drain_ignored");

    // reset mid-operation aborts with no done
    poke(SRA, 32'h8000_0000, 32'd20);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("async_reset_outputs", {dataOut, busy, done, err}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    issue(SRL, 32'hF000_0000, 32'd31);
    drain("drain_srl31");

    issue(ROTR, 32'h0000_0001, 32'd1);
    drain("drain_rotr1");
    issue(ROTR, 32'hA5A5_0F0F, 32'd13);
    drain("drain_rotr13");

    // back-to-back accepts from DONE
    issue(SRA, 32'h7FFF_0000, 32'd2);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 10 && !done; j++) begin
        @(posedge clk); #1;
      end
      if (i == 0) issue(SRL, 32'hCAFE_F00D, 32'd0);
      else if (i == 1) issue(BAD, 32'h1, 32'd9);
      else issue(SRA, 32'h9000_0000, 32'd3);
    end
    drain("drain_b2b");

    for (int i = 0; i < 24; i++) begin
      issue(ops[$urandom_range(0, 3)], $urandom, $urandom);
      drain("drain_rand");
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
